// File: rtl/pipelined_alu_processor.sv
// Five-stage integer pipeline (fetch/decode/execute/memory/writeback) with a
// multi-op ALU, I-type immediates, full operand forwarding and retire/illegal
// counters. It drives an external instruction memory and register file.
//
// Fetch handshake: instruction_valid high at a rising edge means
// current_instruction (the word at PC) is consumed and PC advances by 4;
// instruction_valid low means nothing is consumed, PC holds and a bubble
// enters decode. There is no back-pressure towards the instruction memory.
module pipelined_alu_processor #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 6,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic [31:0]               PC,
  input  logic [31:0]               current_instruction,
  input  logic                      instruction_valid,
  output logic [REG_ADDR_WIDTH-1:0] register_file_read_address_1,
  output logic [REG_ADDR_WIDTH-1:0] register_file_read_address_2,
  input  logic [DATA_WIDTH-1:0]     register_file_read_value_1,
  input  logic [DATA_WIDTH-1:0]     register_file_read_value_2,
  output logic [REG_ADDR_WIDTH-1:0] register_file_write_address,
  output logic [DATA_WIDTH-1:0]     register_file_write_value,
  output logic                      register_file_write_enable,
  output logic                      register_file_reset,
  output logic [COUNT_WIDTH-1:0]    retired_count,
  output logic [COUNT_WIDTH-1:0]    illegal_count
);

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_e;

  // Fetch / F-D state
  logic [31:0] pc_q, pc_d;
  logic        fd_valid_q;
  logic [31:0] fd_instr_q;

  // D-E state
  logic                      de_valid_q, de_use_imm_q;
  alu_op_e                   de_op_q;
  logic [REG_ADDR_WIDTH-1:0] de_rs_q, de_rt_q, de_dest_q;
  logic [DATA_WIDTH-1:0]     de_a_q, de_b_q, de_imm_q;
  logic [4:0]                de_shamt_q;

  // E-M and M-W state (memory stage is a plain register stage)
  logic                      em_valid_q, mw_valid_q;
  logic [REG_ADDR_WIDTH-1:0] em_dest_q, mw_dest_q;
  logic [DATA_WIDTH-1:0]     em_result_q, mw_result_q;

  // Counters
  logic [COUNT_WIDTH-1:0] retired_q, retired_d, illegal_q, illegal_d;

  // Decode-stage fields
  logic [5:0]                opcode, funct;
  logic [REG_ADDR_WIDTH-1:0] rs_a, rt_a, rd_a;
  logic [15:0]               imm16;
  logic                      dec_legal, dec_use_imm;
  alu_op_e                   dec_op;
  logic [REG_ADDR_WIDTH-1:0] dec_dest;
  logic [DATA_WIDTH-1:0]     dec_imm, dec_rs_val, dec_rt_val;
  logic                      wb_we;

  // Execute-stage signals
  logic [DATA_WIDTH-1:0] fwd_a, fwd_b, op_b, ex_result;

  assign opcode = fd_instr_q[31:26];
  assign funct  = fd_instr_q[5:0];
  assign rs_a   = REG_ADDR_WIDTH'(fd_instr_q[25:21]);
  assign rt_a   = REG_ADDR_WIDTH'(fd_instr_q[20:16]);
  assign rd_a   = REG_ADDR_WIDTH'(fd_instr_q[15:11]);
  assign imm16  = fd_instr_q[15:0];

  assign PC                           = pc_q;
  assign register_file_read_address_1 = rs_a;
  assign register_file_read_address_2 = rt_a;
  assign register_file_reset          = reset;
  assign wb_we                        = mw_valid_q && (mw_dest_q != '0);
  assign register_file_write_enable   = wb_we;
  assign register_file_write_address  = mw_dest_q;
  assign register_file_write_value    = mw_result_q;
  assign retired_count                = retired_q;
  assign illegal_count                = illegal_q;

  // Decode: classify the F-D instruction and pick ALU op, immediate and destination
  always_comb begin
    dec_legal   = 1'b0;
    dec_use_imm = 1'b0;
    dec_op      = ALU_ADD;
    dec_dest    = rd_a;
    dec_imm     = '0;
    case (opcode)
      6'h00: begin
        dec_legal = 1'b1;
        case (funct)
          6'h20:   dec_op = ALU_ADD;
          6'h22:   dec_op = ALU_SUB;
          6'h24:   dec_op = ALU_AND;
          6'h25:   dec_op = ALU_OR;
          6'h26:   dec_op = ALU_XOR;
          6'h2A:   dec_op = ALU_SLT;
          6'h00:   dec_op = ALU_SLL;
          6'h02:   dec_op = ALU_SRL;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08: begin
        dec_legal   = 1'b1;
        dec_use_imm = 1'b1;
        dec_op      = ALU_ADD;
        dec_dest    = rt_a;
        dec_imm     = DATA_WIDTH'($signed(imm16));
      end
      6'h0C, 6'h0D: begin
        dec_legal   = 1'b1;
        dec_use_imm = 1'b1;
        dec_op      = (opcode == 6'h0C) ? ALU_AND : ALU_OR;
        dec_dest    = rt_a;
        dec_imm     = DATA_WIDTH'(imm16);
      end
      default: dec_legal = 1'b0;
    endcase
    // A write landing this cycle is not yet visible in the register file
    dec_rs_val = (wb_we && (mw_dest_q == rs_a)) ? mw_result_q : register_file_read_value_1;
    dec_rt_val = (wb_we && (mw_dest_q == rt_a)) ? mw_result_q : register_file_read_value_2;
  end

  // Execute: forward from E-M first, then M-W, then the latched operand; compute result
  always_comb begin
    fwd_a = de_a_q;
    if (em_valid_q && (em_dest_q != '0) && (em_dest_q == de_rs_q))      fwd_a = em_result_q;
    else if (mw_valid_q && (mw_dest_q != '0) && (mw_dest_q == de_rs_q)) fwd_a = mw_result_q;
    fwd_b = de_b_q;
    if (em_valid_q && (em_dest_q != '0) && (em_dest_q == de_rt_q))      fwd_b = em_result_q;
    else if (mw_valid_q && (mw_dest_q != '0) && (mw_dest_q == de_rt_q)) fwd_b = mw_result_q;
    op_b      = de_use_imm_q ? de_imm_q : fwd_b;
    ex_result = '0;
    case (de_op_q)
      ALU_ADD: ex_result = fwd_a + op_b;
      ALU_SUB: ex_result = fwd_a - op_b;
      ALU_AND: ex_result = fwd_a & op_b;
      ALU_OR:  ex_result = fwd_a | op_b;
      ALU_XOR: ex_result = fwd_a ^ op_b;
      ALU_SLT: ex_result[0] = ($signed(fwd_a) < $signed(op_b));
      ALU_SLL: ex_result = (int'(de_shamt_q) >= DATA_WIDTH) ? '0 : (fwd_b << de_shamt_q);
      ALU_SRL: ex_result = (int'(de_shamt_q) >= DATA_WIDTH) ? '0 : (fwd_b >> de_shamt_q);
      default: ex_result = '0;
    endcase
  end

  // Next-state for PC and the two wrapping counters
  always_comb begin
    pc_d      = instruction_valid ? (pc_q + 32'd4) : pc_q;
    retired_d = mw_valid_q ? (retired_q + COUNT_WIDTH'(1)) : retired_q;
    illegal_d = (fd_valid_q && !dec_legal) ? (illegal_q + COUNT_WIDTH'(1)) : illegal_q;
  end

  // Fetch: advance PC and capture the instruction, or insert a bubble on stall
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      fd_valid_q <= 1'b0;
      fd_instr_q <= '0;
    end else begin
      pc_q       <= pc_d;
      fd_valid_q <= instruction_valid;
      fd_instr_q <= current_instruction;
    end
  end

  // Decode to execute register; illegal encodings become bubbles here
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      de_valid_q   <= 1'b0;
      de_use_imm_q <= 1'b0;
      de_op_q      <= ALU_ADD;
      de_rs_q      <= '0;
      de_rt_q      <= '0;
      de_dest_q    <= '0;
      de_a_q       <= '0;
      de_b_q       <= '0;
      de_imm_q     <= '0;
      de_shamt_q   <= '0;
    end else begin
      de_valid_q   <= fd_valid_q && dec_legal;
      de_use_imm_q <= dec_use_imm;
      de_op_q      <= dec_op;
      de_rs_q      <= rs_a;
      de_rt_q      <= rt_a;
      de_dest_q    <= dec_dest;
      de_a_q       <= dec_rs_val;
      de_b_q       <= dec_rt_val;
      de_imm_q     <= dec_imm;
      de_shamt_q   <= fd_instr_q[10:6];
    end
  end

  // Execute to memory, memory to writeback, and the counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      em_valid_q  <= 1'b0;
      em_dest_q   <= '0;
      em_result_q <= '0;
      mw_valid_q  <= 1'b0;
      mw_dest_q   <= '0;
      mw_result_q <= '0;
      retired_q   <= '0;
      illegal_q   <= '0;
    end else begin
      em_valid_q  <= de_valid_q;
      em_dest_q   <= de_dest_q;
      em_result_q <= ex_result;
      mw_valid_q  <= em_valid_q;
      mw_dest_q   <= em_dest_q;
      mw_result_q <= em_result_q;
      retired_q   <= retired_d;
      illegal_q   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_pipelined_alu_processor.sv
// Bench for pipelined_alu_processor: a 32-bit and a 16-bit instance fetch the
// same program from a shared instruction memory; each has its own register
// file model and a log of {address, value, cycle} for every write.
module tb_pipelined_alu_processor;

  localparam int AW = 6;
  localparam int LW = AW + 32 + 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared instruction memory ----------------
  logic [31:0] imem [0:63];
  int          prog_len = 0;
  logic        stall = 1'b0;

  // ---------------- 32-bit instance ----------------
  logic [31:0]   pc32, ci32, rv1_32, rv2_32, wv32, ret32, ill32;
  logic          iv32, we32, rfr32;
  logic [AW-1:0] ra1_32, ra2_32, wa32;
  logic [31:0]   rf32 [0:63];
  logic [31:0]   init32 [0:63];
  logic [LW-1:0] log32 [$];

  // ---------------- 16-bit instance ----------------
  logic [31:0]   pc16, ci16, ret16, ill16;
  logic [15:0]   rv1_16, rv2_16, wv16;
  logic          iv16, we16, rfr16;
  logic [AW-1:0] ra1_16, ra2_16, wa16;
  logic [15:0]   rf16 [0:63];
  logic [15:0]   init16 [0:63];
  logic [LW-1:0] log16 [$];

  int cyc = 0;

  assign ci32   = imem[pc32[7:2]];
  assign iv32   = (int'(pc32 >> 2) < prog_len) && !stall;
  assign rv1_32 = rf32[ra1_32];
  assign rv2_32 = rf32[ra2_32];
  assign ci16   = imem[pc16[7:2]];
  assign iv16   = (int'(pc16 >> 2) < prog_len) && !stall;
  assign rv1_16 = rf16[ra1_16];
  assign rv2_16 = rf16[ra2_16];

  pipelined_alu_processor #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(AW), .COUNT_WIDTH(32)) dut32 (
    .clock(clk), .reset(rst), .PC(pc32),
    .current_instruction(ci32), .instruction_valid(iv32),
    .register_file_read_address_1(ra1_32), .register_file_read_address_2(ra2_32),
    .register_file_read_value_1(rv1_32), .register_file_read_value_2(rv2_32),
    .register_file_write_address(wa32), .register_file_write_value(wv32),
    .register_file_write_enable(we32), .register_file_reset(rfr32),
    .retired_count(ret32), .illegal_count(ill32)
  );

  pipelined_alu_processor #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(AW), .COUNT_WIDTH(32)) dut16 (
    .clock(clk), .reset(rst), .PC(pc16),
    .current_instruction(ci16), .instruction_valid(iv16),
    .register_file_read_address_1(ra1_16), .register_file_read_address_2(ra2_16),
    .register_file_read_value_1(rv1_16), .register_file_read_value_2(rv2_16),
    .register_file_write_address(wa16), .register_file_write_value(wv16),
    .register_file_write_enable(we16), .register_file_reset(rfr16),
    .retired_count(ret16), .illegal_count(ill16)
  );

  // Register file models (non write-through) plus write logs stamped with the edge index
  always @(posedge clk) begin
    if (rst) begin
      cyc <= 0;
      for (int i = 0; i < 64; i++) begin
        rf32[i] <= init32[i];
        rf16[i] <= init16[i];
      end
    end else begin
      cyc <= cyc + 1;
      if (we32) begin
        rf32[wa32] <= wv32;
        log32.push_back({wa32, wv32, cyc[7:0]});
      end
      if (we16) begin
        rf16[wa16] <= wv16;
        log16.push_back({wa16, 16'h0000, wv16, cyc[7:0]});
      end
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [LW-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_wr(input logic [5:0] addr, input logic [31:0] val, input int c);
    exp_q.push_back({addr, val, 8'(c)});
  endtask

  task automatic check_log(input bit sel, input string name);
    int n;
    n = sel ? log16.size() : log32.size();
    check({name, "_nwr"}, 64'(n), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < n) check($sformatf("%s_wr%0d", name, i), 64'(sel ? log16[i] : log32[i]), 64'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] r_enc(input int rs, input int rt, input int rd,
                                        input int sh, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] i_enc(input logic [5:0] op, input int rs, input int rt,
                                        input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic clear_init();
    for (int i = 0; i < 64; i++) begin
      init32[i] = '0;
      init16[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    stall = 1'b0;
    @(posedge clk);
    log32.delete();
    log16.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_we;
    logic [5:0]  exp_addr;
    logic [31:0] exp_val;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [0:15];

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = '0;
    clear_init();

    vecs[0]  = '{r_enc(1, 2, 3, 0, 6'h20), 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 6'd3, 32'h8000_0000, 1'b0};
    vecs[1]  = '{r_enc(1, 2, 3, 0, 6'h20), 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 6'd3, 32'h0000_0001, 1'b0};
    vecs[2]  = '{r_enc(1, 2, 3, 0, 6'h22), 32'h0000_0005, 32'h0000_0007, 1'b1, 6'd3, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{r_enc(1, 2, 3, 0, 6'h24), 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, 6'd3, 32'h00F0_1200, 1'b0};
    vecs[4]  = '{r_enc(1, 2, 3, 0, 6'h25), 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, 6'd3, 32'hFFF0_FF34, 1'b0};
    vecs[5]  = '{r_enc(1, 2, 3, 0, 6'h26), 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, 6'd3, 32'hFF00_ED34, 1'b0};
    vecs[6]  = '{r_enc(1, 2, 3, 0, 6'h2A), 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 6'd3, 32'h0000_0001, 1'b0};
    vecs[7]  = '{r_enc(1, 2, 3, 0, 6'h2A), 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 6'd3, 32'h0000_0000, 1'b0};
    vecs[8]  = '{r_enc(0, 2, 3, 4, 6'h00), 32'h0000_0000, 32'h8000_000F, 1'b1, 6'd3, 32'h0000_00F0, 1'b0};
    vecs[9]  = '{r_enc(0, 2, 3, 31, 6'h02), 32'h0000_0000, 32'h8000_0000, 1'b1, 6'd3, 32'h0000_0001, 1'b0};
    vecs[10] = '{i_enc(6'h08, 1, 5, 16'hFFFE), 32'h0000_0005, 32'h0, 1'b1, 6'd5, 32'h0000_0003, 1'b0};
    vecs[11] = '{i_enc(6'h0C, 1, 3, 16'h8F0F), 32'hFFFF_FFFF, 32'h0, 1'b1, 6'd3, 32'h0000_8F0F, 1'b0};
    vecs[12] = '{i_enc(6'h0D, 1, 3, 16'h8000), 32'h0000_0001, 32'h0, 1'b1, 6'd3, 32'h0000_8001, 1'b0};
    vecs[13] = '{r_enc(1, 2, 0, 0, 6'h20), 32'h0000_0001, 32'h0000_0002, 1'b0, 6'd0, 32'h0, 1'b0};
    vecs[14] = '{32'hFC00_0000, 32'h1, 32'h2, 1'b0, 6'd0, 32'h0, 1'b1};
    vecs[15] = '{r_enc(1, 2, 3, 0, 6'h21), 32'h1, 32'h2, 1'b0, 6'd0, 32'h0, 1'b1};

    // ---- reset state (reset held from time 0) ----
    @(negedge clk);
    check("rst_pc", 64'(pc32), 64'h0);
    check("rst_we", 64'(we32), 64'h0);
    check("rst_wa", 64'(wa32), 64'h0);
    check("rst_wv", 64'(wv32), 64'h0);
    check("rst_ret", 64'(ret32), 64'h0);
    check("rst_ill", 64'(ill32), 64'h0);
    check("rst_rfreset_hi", 64'(rfr32), 64'h1);

    // ---- single-instruction ALU vectors ----
    for (int v = 0; v < 16; v++) begin
      clear_init();
      init32[1] = vecs[v].a;
      init32[2] = vecs[v].b;
      imem[0]   = vecs[v].instr;
      prog_len  = 1;
      do_reset();
      if (v == 0) check("rfreset_lo", 64'(rfr32), 64'h0);
      run(8);
      if (vecs[v].exp_we) expect_wr(vecs[v].exp_addr, vecs[v].exp_val, 4);
      check_log(1'b0, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_ret", v), 64'(ret32), 64'(!vecs[v].exp_ill));
      check($sformatf("vec%0d_ill", v), 64'(ill32), 64'(vecs[v].exp_ill));
    end

    // ---- back-to-back dependent sequence ----
    clear_init();
    imem[0] = i_enc(6'h08, 0, 1, 16'd5);
    imem[1] = i_enc(6'h08, 0, 2, 16'd7);
    imem[2] = r_enc(1, 2, 3, 0, 6'h20);
    prog_len = 3;
    do_reset();
    run(10);
    expect_wr(6'd1, 32'd5, 4);
    expect_wr(6'd2, 32'd7, 5);
    expect_wr(6'd3, 32'd12, 6);
    check_log(1'b0, "seq3");
    check("seq3_ret", 64'(ret32), 64'd3);

    // ---- dependency chain with 0..3 NOPs before the dependent sub ----
    for (int nops = 0; nops < 4; nops++) begin
      for (int k = 0; k < nops; k++) imem[3 + k] = 32'h0000_0000;
      imem[3 + nops] = r_enc(3, 1, 4, 0, 6'h22);
      prog_len = 4 + nops;
      do_reset();
      run(14);
      expect_wr(6'd1, 32'd5, 4);
      expect_wr(6'd2, 32'd7, 5);
      expect_wr(6'd3, 32'd12, 6);
      expect_wr(6'd4, 32'd7, 7 + nops);
      check_log(1'b0, $sformatf("fwd_nop%0d", nops));
      check($sformatf("fwd_nop%0d_ret", nops), 64'(ret32), 64'(4 + nops));
    end

    // ---- fetch stall of 3 cycles after two instructions ----
    imem[3] = r_enc(3, 1, 4, 0, 6'h22);
    prog_len = 4;
    do_reset();
    run(2);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run(1);
      check($sformatf("stall_pc%0d", k), 64'(pc32), 64'd8);
    end
    stall = 1'b0;
    run(12);
    expect_wr(6'd1, 32'd5, 4);
    expect_wr(6'd2, 32'd7, 5);
    expect_wr(6'd3, 32'd12, 9);
    expect_wr(6'd4, 32'd7, 10);
    check_log(1'b0, "stall");
    check("stall_ret", 64'(ret32), 64'd4);

    // ---- 16-bit datapath: sign-extended immediate, srl, slt, oversize shift ----
    clear_init();
    imem[0] = i_enc(6'h08, 0, 1, 16'hFFFF);
    imem[1] = r_enc(0, 1, 2, 4, 6'h02);
    imem[2] = r_enc(1, 0, 3, 0, 6'h2A);
    imem[3] = r_enc(0, 1, 4, 20, 6'h00);
    prog_len = 4;
    do_reset();
    run(10);
    expect_wr(6'd1, 32'h0000_FFFF, 4);
    expect_wr(6'd2, 32'h0000_0FFF, 5);
    expect_wr(6'd3, 32'h0000_0001, 6);
    expect_wr(6'd4, 32'h0000_0000, 7);
    check_log(1'b1, "w16");
    expect_wr(6'd1, 32'hFFFF_FFFF, 4);
    expect_wr(6'd2, 32'h0FFF_FFFF, 5);
    expect_wr(6'd3, 32'h0000_0001, 6);
    expect_wr(6'd4, 32'hFFF0_0000, 7);
    check_log(1'b0, "w32");
    check("w16_ret", 64'(ret16), 64'd4);

    // ---- r0 destination followed by an illegal opcode ----
    clear_init();
    init32[1] = 32'd3;
    init32[2] = 32'd4;
    imem[0] = r_enc(1, 2, 0, 0, 6'h20);
    imem[1] = 32'hFC00_0000;
    prog_len = 2;
    do_reset();
    run(10);
    check_log(1'b0, "r0_ill");
    check("r0_ill_ill", 64'(ill32), 64'd1);
    check("r0_ill_ret", 64'(ret32), 64'd1);

    // ---- reset for one cycle with four instructions in flight ----
    imem[0] = r_enc(1, 2, 0, 0, 6'h20);
    imem[1] = i_enc(6'h08, 0, 2, 16'h0011);
    imem[2] = i_enc(6'h08, 0, 3, 16'h0022);
    imem[3] = i_enc(6'h08, 0, 4, 16'h0033);
    imem[4] = i_enc(6'h08, 0, 5, 16'h0044);
    prog_len = 5;
    do_reset();
    run(4);
    check("mid_we_before", 64'(we32), 64'h0);
    rst = 1'b1;
    #1;
    check("mid_we_async", 64'(we32), 64'h0);
    check("mid_pc", 64'(pc32), 64'h0);
    check("mid_ret", 64'(ret32), 64'h0);
    check("mid_ill", 64'(ill32), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    check_log(1'b0, "mid_nowrite");
    run(12);
    expect_wr(6'd2, 32'h11, 5);
    expect_wr(6'd3, 32'h22, 6);
    expect_wr(6'd4, 32'h33, 7);
    expect_wr(6'd5, 32'h44, 8);
    check_log(1'b0, "mid_restart");
    check("mid_restart_ret", 64'(ret32), 64'd5);
    check("mid_restart_pc", 64'(pc32), 64'd20);

    // ---- final report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_alu_processor.md
# pipelined_alu_processor

Parametrised five-stage (fetch/decode/execute/memory/writeback) integer pipeline driving an external instruction memory and external register file. It extends the add-only pipeline with a multi-op ALU, I-type immediates, operand forwarding, fetch stalls, r0 write suppression, and retire/illegal counters. It sits between the instruction memory (PC out, instruction in) and the register file (two combinational read ports, one write port).

## Interface
- DATA_WIDTH, 32: datapath and register width; legal range 16..64.
- REG_ADDR_WIDTH, 6: register file address port width; minimum 5, instruction fields zero-extended.
- COUNT_WIDTH, 32: width of the retire and illegal counters.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- PC  out  32  fetch address, byte addressed.
- current_instruction  in  32  instruction at PC, valid in the same cycle.
- instruction_valid  in  1  current_instruction is valid; low means fetch stall.
- register_file_read_address_1 / _2  out  REG_ADDR_WIDTH  rs / rt from the decode-stage instruction.
- register_file_read_value_1 / _2  in  DATA_WIDTH  combinational read data.
- register_file_write_address  out  REG_ADDR_WIDTH  writeback destination.
- register_file_write_value  out  DATA_WIDTH  writeback data.
- register_file_write_enable  out  1  writeback strobe.
- register_file_reset  out  1  equals reset.
- retired_count  out  COUNT_WIDTH  legal instructions leaving writeback.
- illegal_count  out  COUNT_WIDTH  unsupported encodings dropped in decode.

## Operation
- Fetch:
  - instruction_valid high at the edge: the F/D register captures the instruction with valid=1, and PC += 4 (wraps mod 2^32).
  - instruction_valid low: PC holds and F/D captures a bubble (valid=0).
- Decode: fields are opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0].
- R-type (opcode 0x00), dest=rd:
  - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor.
  - 0x2A slt: signed compare, result 1/0.
  - 0x00 sll and 0x02 srl: operate on rt by shamt; a shift ≥ DATA_WIDTH gives 0.
- I-type, dest=rt:
  - 0x08 addi: imm sign-extended to DATA_WIDTH.
  - 0x0C andi, 0x0D ori: imm zero-extended.
- Any other encoding: becomes a bubble and increments illegal_count. Only valid F/D entries are counted.
- Destination 0: the instruction flows through the pipeline and retires, but register_file_write_enable stays low for it. Register 0 is never a forwarding source.
- Arithmetic is modulo 2^DATA_WIDTH; there is no overflow trap.
- Forwarding, at execute-operand select, in priority order:
  1. E/M result if its dest matches the source register, valid, and non-zero.
  2. M/W result, same conditions.
  3. Latched D/E operand.
- Read-during-write at decode: if the W-stage write targets rs or rt in the same cycle, decode latches the W value instead of the register file value. The register file is therefore not required to be write-through.
- With this forwarding, no data-hazard stall is ever needed.
- The memory stage is a pure register stage.
- Writeback: the M/W register drives the write port. register_file_write_enable = valid && dest≠0.
- Counters:
  - retired_count increments when the M/W entry is valid, including dest 0.
  - Both counters wrap.

## Timing
- Reset (async assert) values:
  - PC=0, all stage valids=0, write_enable=0, write_address=0, write_value=0, both counts=0.
  - Deassertion is taken at the next rising edge.
- Latency: an instruction presented at PC in cycle n is written in cycle n+4. Fetch edge is at n, and write_enable is high during n+4 (the D/E, E/M, M/W edges are n+1, n+2, n+3).
- A dependent instruction issued the very next cycle receives the forwarded value with zero bubbles.
- A stall bubble moves down the pipe like a dropped instruction: no write, no retire.
- Reset mid-stream: all in-flight instructions are discarded with no write. write_enable drops asynchronously.
- Throughput: one instruction per cycle while instruction_valid is high.

## Test plan
- Reset, then addi r1,r0,5; addi r2,r0,7; add r3,r1,r2 back-to-back -> r3=12 written in cycle 6 after the first fetch; retired_count=3.
- Chain of dependencies: sub r4,r3,r1 directly after writing r3 (E/M forward), then with 1 and 2 intervening NOPs (M/W and decode read-during-write forward) -> r4=7 in all three cases.
- DATA_WIDTH=16: addi r1,r0,-1; srl r2,r1,4; slt r3,r1,r0 -> r1=0xFFFF, r2=0x0FFF, r3=1.
- instruction_valid low for 3 cycles mid-stream -> PC holds for 3 cycles, there are no extra writes, and results are identical to the unstalled run.
- add r0,r1,r2, then an illegal opcode 0x3F -> no write_enable; illegal_count=1; retired_count counts the r0 instruction.
- Assert reset for 1 cycle while 4 instructions are in flight -> write_enable stays 0, PC=0, counters=0, and the pipeline restarts cleanly.
